// File: rtl/cpu_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Purpose : shared encodings for the CPU instruction-sequencing controller.
//           Holds the state enumeration, the opcode/op field values, the
//           mem_cmd, vsel, one-hot nsel and branch-condition codes, plus the
//           registered-output record and a helper that maps each state to
//           its strobe pattern.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_MOVI, S_GETA, S_GETB, S_EXEC, S_WB,
        S_LGETA, S_SGETA, S_CALC, S_LADDR, S_MRD, S_LWB,
        S_SGETB, S_PASS, S_MWR, S_BR, S_HALT
    } state_t;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_MVN   = 2'b11;
    localparam logic [1:0] OP_MOVSH = 2'b00;
    localparam logic [1:0] OP_MOVI  = 2'b10;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_sel;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_out_t;

    // True for every opcode/op pair the decoder knows how to sequence.
    function automatic logic isLegal(input logic [2:0] opc, input logic [1:0] op);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_MOV: ok = (op == OP_MOVI) || (op == OP_MOVSH);
            OPC_ALU, OPC_LDR, OPC_STR, OPC_BR, OPC_HALT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Strobe pattern for a state. EXEC needs the instruction fields because
    // CMP updates status instead of C, and MVN / MOV-shift zero the A input.
    // The branch load_pc is flag-dependent and is added outside this table.
    function automatic ctrl_out_t stateOutputs(input state_t s,
                                               input logic [2:0] opc,
                                               input logic [1:0] op);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_RST:  begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
            S_IF1:  begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; end
            S_IF2:  begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; o.load_ir = 1'b1; end
            S_UPC:  o.load_pc = 1'b1;
            S_MOVI: begin o.nsel = NSEL_RN; o.vsel = VSEL_IMM; o.write = 1'b1; end
            S_GETA, S_LGETA, S_SGETA: begin o.nsel = NSEL_RN; o.loada = 1'b1; end
            S_GETB: begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
            S_EXEC: begin
                if (opc == OPC_ALU && op == OP_CMP) o.loads = 1'b1;
                else                                o.loadc = 1'b1;
                o.asel = (opc == OPC_ALU && op == OP_MVN) ||
                         (opc == OPC_MOV && op == OP_MOVSH);
            end
            S_WB:    begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
            S_CALC:  begin o.bsel = 1'b1; o.loadc = 1'b1; end
            S_LADDR: o.load_addr = 1'b1;
            S_MRD:   o.mem_cmd = MEM_READ;
            S_LWB:   begin o.mem_cmd = MEM_READ; o.nsel = NSEL_RD; o.vsel = VSEL_MDATA; o.write = 1'b1; end
            S_SGETB: begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
            S_PASS:  begin o.asel = 1'b1; o.loadc = 1'b1; end
            S_MWR:   o.mem_cmd = MEM_WRITE;
            S_BR:    o.pc_sel = 1'b1;
            S_HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm_if
// Purpose : bundle between the controller and the datapath / memory side.
// Signals : opcode, op, cond, N, V, Z   decoded fields and status flags
//           nsel ... halted              every controller strobe
//           illegal                      only with CTRL_ILLEGAL_HALT_EN
// Modports: master = controller, slave = datapath/memory/decoder side.
// ---------------------------------------------------------------------------
interface cpu_control_fsm_if;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic       N;
    logic       V;
    logic       Z;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_sel;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic       illegal;
`endif

    modport master (
        input  opcode, op, cond, N, V, Z,
        output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr,
               mem_cmd, halted
`ifdef CTRL_ILLEGAL_HALT_EN
        , output illegal
`endif
    );

    modport slave (
        output opcode, op, cond, N, V, Z,
        input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr,
               mem_cmd, halted
`ifdef CTRL_ILLEGAL_HALT_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/cpu_control_fsm_branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purpose : combinational branch-condition evaluator, kept separate so a
//           later BL/BX extension can reuse it.
// Ports   : i_cond [2:0] condition code, i_n/i_v/i_z status flags,
//           o_taken       1 when the branch should be taken
// ---------------------------------------------------------------------------
module branch_cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_n,
    input  logic       i_v,
    input  logic       i_z,
    output logic       o_taken
);

    // Signed less-than is N^V; unused codes never branch.
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_AL: o_taken = 1'b1;
            COND_EQ: o_taken = i_z;
            COND_NE: o_taken = ~i_z;
            COND_LT: o_taken = i_n ^ i_v;
            COND_LE: o_taken = (i_n ^ i_v) | i_z;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
// Purpose : fetch / decode / execute sequencer. Moore machine with
//           registered strobes; only the branch load_pc follows the flags
//           combinationally.
// Ports   : clk    rising-edge clock
//           reset  synchronous active-high, returns to RST
//           bus    cpu_control_fsm_if.master (fields, flags, all strobes)
// Params  : MEM_WAIT (0..7) extra cycles each memory read is held
// Config  : CTRL_ILLEGAL_HALT_EN - unknown opcode/op halts and raises a
//           sticky 'illegal' output; otherwise it is treated as a NOP.
// ---------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
)(
    input  logic                clk,
    input  logic                reset,
    cpu_control_fsm_if.master   bus
);

`ifdef CTRL_ILLEGAL_HALT_EN
    localparam state_t ILLEGAL_NEXT = S_HALT;
`else
    localparam state_t ILLEGAL_NEXT = S_IF1;
`endif

    state_t     r_state;
    ctrl_out_t  r_out;
    logic [2:0] r_waitCnt;
    logic       r_isStore;
    state_t     w_nextState;
    logic       w_waitDone;
    logic       w_taken;

    // The counter starts at zero on entry to a wait state, so the state is
    // held for MEM_WAIT extra cycles.
    assign w_waitDone = (r_waitCnt == 3'(MEM_WAIT));

    // Next-state map. LADDR is shared by loads and stores, so the flavour
    // latched at decode picks the branch out of it.
    function automatic state_t nextState(input state_t s,
                                         input logic [2:0] opc,
                                         input logic [1:0] op,
                                         input logic waitDone,
                                         input logic isStore);
        state_t n;
        n = S_RST;
        case (s)
            S_RST:   n = S_IF1;
            S_IF1:   n = waitDone ? S_IF2 : S_IF1;
            S_IF2:   n = S_UPC;
            S_UPC:   n = S_DEC;
            S_DEC: begin
                case (opc)
                    OPC_MOV:  n = (op == OP_MOVI)  ? S_MOVI :
                                  (op == OP_MOVSH) ? S_GETB : ILLEGAL_NEXT;
                    OPC_ALU:  n = (op == OP_MVN) ? S_GETB : S_GETA;
                    OPC_LDR:  n = S_LGETA;
                    OPC_STR:  n = S_SGETA;
                    OPC_BR:   n = S_BR;
                    OPC_HALT: n = S_HALT;
                    default:  n = ILLEGAL_NEXT;
                endcase
            end
            S_MOVI:  n = S_IF1;
            S_GETA:  n = S_GETB;
            S_GETB:  n = S_EXEC;
            S_EXEC:  n = (opc == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WB;
            S_WB:    n = S_IF1;
            S_LGETA, S_SGETA: n = S_CALC;
            S_CALC:  n = S_LADDR;
            S_LADDR: n = isStore ? S_SGETB : S_MRD;
            S_MRD:   n = waitDone ? S_LWB : S_MRD;
            S_LWB:   n = S_IF1;
            S_SGETB: n = S_PASS;
            S_PASS:  n = S_MWR;
            S_MWR:   n = S_IF1;
            S_BR:    n = S_IF1;
            S_HALT:  n = S_HALT;
            default: n = S_RST;
        endcase
        return n;
    endfunction

    assign w_nextState = nextState(r_state, bus.opcode, bus.op, w_waitDone, r_isStore);

    branch_cond_eval u_branchCond (
        .i_cond  (bus.cond),
        .i_n     (bus.N),
        .i_v     (bus.V),
        .i_z     (bus.Z),
        .o_taken (w_taken)
    );

`ifdef CTRL_ILLEGAL_HALT_EN
    logic r_illegal;
`endif

    // State register plus the registered strobe pattern of the state being
    // entered, so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RST;
            r_out     <= stateOutputs(S_RST, 3'b000, 2'b00);
            r_waitCnt <= '0;
            r_isStore <= 1'b0;
`ifdef CTRL_ILLEGAL_HALT_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            r_out   <= stateOutputs(w_nextState, bus.opcode, bus.op);
            if ((r_state == S_IF1 || r_state == S_MRD) && !w_waitDone)
                r_waitCnt <= r_waitCnt + 3'd1;
            else
                r_waitCnt <= '0;
            if (r_state == S_DEC)
                r_isStore <= (bus.opcode == OPC_STR);
`ifdef CTRL_ILLEGAL_HALT_EN
            if (r_state == S_DEC && !isLegal(bus.opcode, bus.op))
                r_illegal <= 1'b1;
`endif
        end
    end

`ifdef CTRL_ILLEGAL_HALT_EN
    assign bus.illegal = r_illegal;
`endif

    assign bus.nsel      = r_out.nsel;
    assign bus.vsel      = r_out.vsel;
    assign bus.write     = r_out.write;
    assign bus.loada     = r_out.loada;
    assign bus.loadb     = r_out.loadb;
    assign bus.loadc     = r_out.loadc;
    assign bus.loads     = r_out.loads;
    assign bus.asel      = r_out.asel;
    assign bus.bsel      = r_out.bsel;
    assign bus.load_ir   = r_out.load_ir;
    // Branch target load depends on the live flags while in BR.
    assign bus.load_pc   = r_out.load_pc | ((r_state == S_BR) & w_taken);
    assign bus.reset_pc  = r_out.reset_pc;
    assign bus.pc_sel    = r_out.pc_sel;
    assign bus.addr_sel  = r_out.addr_sel;
    assign bus.load_addr = r_out.load_addr;
    assign bus.mem_cmd   = r_out.mem_cmd;
    assign bus.halted    = r_out.halted;

endmodule
